// File: rtl/cg_ctrl_pkg.sv
// Shared types, parameter limits and helpers for the clock-gating controller.
package cg_ctrl_pkg;

  typedef enum logic [1:0] {
    CG_RUN  = 2'd0,
    CG_OFF  = 2'd1,
    CG_WAKE = 2'd2
  } cg_state_e;

  localparam int CG_MIN_N_CH     = 1;
  localparam int CG_MAX_N_CH     = 64;
  localparam int CG_MIN_CNT_W    = 1;
  localparam int CG_MIN_WAKE_LAT = 1;
  localparam int CG_MIN_EVT_W    = 1;
  localparam int CG_POP_W        = 7;

  function automatic logic [CG_POP_W-1:0] popcount(input logic [CG_MAX_N_CH-1:0] v);
    logic [CG_POP_W-1:0] s;
    s = '0;
    for (int i = 0; i < CG_MAX_N_CH; i++) s = s + CG_POP_W'(v[i]);
    return s;
  endfunction

endpackage

// File: rtl/clock_gate.sv
// Leaf integrated clock gate: transparent-low enable latch ANDed with clk.
module clock_gate (
  input  logic clk,
  input  logic clk_en,
  input  logic se,
  output logic gclk
);

`ifdef DSU_FPGA
  logic unused_en;
  assign unused_en = clk_en | se;
  assign gclk      = clk;
`else
  logic en_lat;

  // Enable can only change while clk is low, so gclk never glitches.
  always_latch begin
    if (!clk) en_lat = clk_en | se;
  end

  assign gclk = clk & en_lat;
`endif

endmodule

// File: rtl/clock_gate_ch.sv
// One gated channel: RUN/OFF/WAKE FSM with idle hysteresis and wake latency.
module clock_gate_ch
  import cg_ctrl_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int WAKE_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             se,
  input  logic             force_on,
  input  logic [CNT_W-1:0] idle_thresh,
  input  logic             busy,
  input  logic             wake_req,
  output logic             gclk,
  output logic             ch_en,
  output logic             ch_ready,
  output logic             gate_evt
);

  localparam int WAKE_W = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;

  cg_state_e          state_q, state_d;
  logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [WAKE_W-1:0]  wake_cnt_q, wake_cnt_d;
  logic               active;
  logic [CNT_W:0]     idle_inc;

  assign active   = busy | wake_req | force_on;
  // One extra bit so an all-ones counter still compares correctly.
  assign idle_inc = (CNT_W+1)'(idle_cnt_q) + (CNT_W+1)'(1);

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    gate_evt   = 1'b0;
    case (state_q)
      CG_RUN: begin
        if (active || (idle_thresh == '0)) begin
          idle_cnt_d = '0;
        end else if (idle_inc >= {1'b0, idle_thresh}) begin
          state_d    = CG_OFF;
          idle_cnt_d = '0;
          gate_evt   = 1'b1;
        end else begin
          idle_cnt_d = idle_inc[CNT_W-1:0];
        end
      end
      CG_OFF: begin
        if (active) begin
          state_d    = CG_WAKE;
          wake_cnt_d = '0;
        end
      end
      CG_WAKE: begin
        if (wake_cnt_q == WAKE_W'(WAKE_LAT - 1)) begin
          state_d    = CG_RUN;
          wake_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + WAKE_W'(1);
        end
      end
      default: state_d = CG_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CG_RUN;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      ch_en      <= 1'b1;
      ch_ready   <= 1'b1;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      ch_en      <= (state_d != CG_OFF);
      ch_ready   <= (state_d == CG_RUN);
    end
  end

  clock_gate u_gate (
    .clk    (clk),
    .clk_en (ch_en),
    .se     (se),
    .gclk   (gclk)
  );

endmodule

// File: rtl/clock_gate_ctrl.sv
// Multi-channel automatic clock-gating controller with saturating gate-event count.
module clock_gate_ctrl
  import cg_ctrl_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 8,
  parameter int WAKE_LAT = 2,
  parameter int EVT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             se,
  input  logic             force_on,
  input  logic [CNT_W-1:0] idle_thresh,
  input  logic [N_CH-1:0]  busy,
  input  logic [N_CH-1:0]  wake_req,
  output logic [N_CH-1:0]  gclk,
  output logic [N_CH-1:0]  ch_en,
  output logic [N_CH-1:0]  ch_ready,
  output logic [EVT_W-1:0] gate_evt_cnt
);

  localparam int SUM_W = EVT_W + CG_POP_W;

  if (N_CH < CG_MIN_N_CH || N_CH > CG_MAX_N_CH) begin : g_bad_n_ch
    $error("clock_gate_ctrl: N_CH out of range");
  end
  if (CNT_W < CG_MIN_CNT_W || WAKE_LAT < CG_MIN_WAKE_LAT || EVT_W < CG_MIN_EVT_W) begin : g_bad_par
    $error("clock_gate_ctrl: CNT_W, WAKE_LAT or EVT_W below minimum");
  end

  function automatic logic [EVT_W-1:0] sat_evt(input logic [SUM_W-1:0] v);
    if (v > SUM_W'({EVT_W{1'b1}})) return {EVT_W{1'b1}};
    return v[EVT_W-1:0];
  endfunction

  logic [N_CH-1:0]     gate_evt;
  logic [CG_POP_W-1:0] evt_sum;
  logic [SUM_W-1:0]    evt_total;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    clock_gate_ch #(
      .CNT_W    (CNT_W),
      .WAKE_LAT (WAKE_LAT)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .se          (se),
      .force_on    (force_on),
      .idle_thresh (idle_thresh),
      .busy        (busy[i]),
      .wake_req    (wake_req[i]),
      .gclk        (gclk[i]),
      .ch_en       (ch_en[i]),
      .ch_ready    (ch_ready[i]),
      .gate_evt    (gate_evt[i])
    );
  end

  assign evt_sum   = popcount(CG_MAX_N_CH'(gate_evt));
  assign evt_total = SUM_W'(gate_evt_cnt) + SUM_W'(evt_sum);

  always_ff @(posedge clk) begin
    if (rst) gate_evt_cnt <= '0;
    else     gate_evt_cnt <= sat_evt(evt_total);
  end

endmodule

// File: doc/clock_gate_ctrl.md
Name: clock_gate_ctrl

Overview:
- Multi-channel automatic clock-gating controller for DSU/CDB sub-blocks.
- Per channel: watch a busy indication, count idle cycles against a programmable hysteresis threshold, then gate the channel clock.
- Ungates on demand and reports readiness after a fixed wake latency.
- Instantiates one clock_gate leaf cell per channel; DFT scan-enable override and a global force-on are passed through.

Parameters:
- N_CH, 4, number of gated channels (>=1).
- CNT_W, 8, width of idle threshold and idle counter.
- WAKE_LAT, 2, cycles from ungating to ch_ready (>=1).
- EVT_W, 16, width of the saturating gate-event counter.

Ports:
- clk  in  1  free-running source clock.
- rst  in  1  synchronous reset, active-high.
- se  in  1  scan enable; forwarded to every leaf gate, forces gclk running in DFT builds.
- force_on  in  1  global override; all channels held ungated.
- idle_thresh  in  CNT_W  idle cycles before gating; 0 disables auto-gating for all channels.
- busy  in  N_CH  per-channel activity.
- wake_req  in  N_CH  per-channel explicit wake request.
- gclk  out  N_CH  gated clocks.
- ch_en  out  N_CH  registered enable driving each leaf clk_en.
- ch_ready  out  N_CH  channel in RUN state; clock stable.
- gate_evt_cnt  out  EVT_W  saturating count of RUN->OFF transitions, summed over all channels.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- All state updates on the posedge of clk. Inputs are sampled every cycle, including idle_thresh; a mid-count change takes effect immediately.
- Reset values: state=RUN, idle_cnt=0, wake_cnt=0, ch_en=all 1, ch_ready=all 1, gate_evt_cnt=0.
  - Clocks run during and after reset.
  - Reset mid-WAKE or mid-OFF returns the channel to RUN on the next edge.
- Per-channel FSM (independent per channel):
  - RUN: ch_en=1, ch_ready=1.
    - If busy|wake_req|force_on, or idle_thresh==0: idle_cnt<=0 and stay in RUN.
    - Otherwise, if idle_cnt+1 >= idle_thresh (compare at CNT_W+1 bits): go to OFF, ch_en<=0, idle_cnt<=0, request gate event.
    - Otherwise idle_cnt<=idle_cnt+1.
  - OFF: ch_en=0, ch_ready=0.
    - If busy|wake_req|force_on: go to WAKE, ch_en<=1, wake_cnt<=0.
  - WAKE: ch_en=1, ch_ready=0.
    - wake_cnt increments each cycle.
    - When wake_cnt==WAKE_LAT-1: go to RUN, ch_ready<=1.
    - busy or wake_req deasserting during WAKE does not abort the wake.
- Timing examples:
  - idle_thresh=T with busy low from cycle 0: ch_en falls at the edge ending cycle T-1, so gclk stops after T idle cycles.
  - Wake asserted in OFF at cycle k: ch_en=1 after edge k, ch_ready=1 after edge k+WAKE_LAT.
- Simultaneous events:
  - busy rising in the cycle the threshold is reached: busy wins; stay in RUN and clear the counter.
  - force_on wins over gating in every state.
- ch_en feeds the clock_gate clk_en. The leaf latch adds its own transparent-low latch, so gclk edges are glitch-free.
- gclk follows ch_en with one clk of latch delay. In DSU_FPGA builds gclk==clk.
- gate_evt_cnt:
  - Adds the popcount of this cycle's RUN->OFF events.
  - Saturates at all-ones; no wrap.
- Leaf gate se input = se. force_on is not routed to se.

Decomposition:
- Shared package cg_ctrl_pkg:
  - typedef enum logic[1:0] cg_state_e {CG_RUN, CG_OFF, CG_WAKE}.
  - Parameter-range check constants.
  - Popcount function.
- One sub-module, clock_gate_ch: per-channel FSM + counters + existing clock_gate leaf instance.
- Top level: generate loop over N_CH, plus the event counter and saturation logic.

Test Plan:
- Reset with busy=0, idle_thresh=4 -> ch_en=1 for 4 cycles after rst falls, then ch_en=0 and gclk flat; gate_evt_cnt=N_CH (4).
- Channel 1 in OFF, wake_req[1] pulsed 1 cycle, WAKE_LAT=2 -> ch_en[1]=1 next edge, ch_ready[1]=1 two edges after the request, other channels unaffected.
- idle_thresh=3, busy[0] pulses every 3rd cycle -> idle_cnt never reaches 3, ch_en[0] stays 1, gate_evt_cnt unchanged.
- Channel gated, then idle_thresh=0 written and force_on=1 -> all channels WAKE then RUN; no channel regates while force_on=1 or idle_thresh=0.
- EVT_W=4, idle_thresh=1, busy toggled to produce 20 gate events -> gate_evt_cnt stops at 15.
- rst asserted while channel 2 in WAKE at wake_cnt=0 -> next edge ch_en[2]=1, ch_ready[2]=1, idle_cnt=0; se=1 in DFT build -> gclk toggles with ch_en=0.
